// File: rtl/cnn_conv2_pkg.sv
// Shared widths and FSM encoding for the conv2 MAC scheduler.
package cnn_conv2_pkg;
  localparam int A_W    = 14;
  localparam int B_W    = 9;
  localparam int P_W    = A_W + B_W;
  localparam int ACC_W  = 32;
  localparam int ADDR_W = 8;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;
endpackage

// File: rtl/cnn_conv2_mac_acc.sv
// Product register, read/product valid pipeline and sign-extending accumulator.
module cnn_conv2_mac_acc #(
  parameter int P_W   = cnn_conv2_pkg::P_W,
  parameter int ACC_W = cnn_conv2_pkg::ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             rd_issue,
  input  logic [P_W-1:0]   mul_p,
  output logic [ACC_W-1:0] acc
);
  localparam int STAGES = 2;

  // vld_pipe[1] = rd_v (read data on the buses), vld_pipe[2] = p_v (p_r holds a product)
  logic [STAGES:1] vld_pipe;
  logic [P_W-1:0]  p_r;
  logic            rd_v, p_v;

  assign rd_v = vld_pipe[1];
  assign p_v  = vld_pipe[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      p_r      <= '0;
      acc      <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], rd_issue};
      if (rd_v) p_r <= mul_p;
      if (clr)      acc <= '0;
      else if (p_v) acc <= acc + {{(ACC_W-P_W){p_r[P_W-1]}}, p_r};
    end
  end
endmodule

// File: rtl/cnn_conv2_mac_sched.sv
// Conv2 dot-product sequencer: walks n_taps buffer pairs through the shared multiplier.
module cnn_conv2_mac_sched #(
  parameter int A_W    = cnn_conv2_pkg::A_W,
  parameter int B_W    = cnn_conv2_pkg::B_W,
  parameter int P_W    = cnn_conv2_pkg::P_W,
  parameter int ACC_W  = cnn_conv2_pkg::ACC_W,
  parameter int ADDR_W = cnn_conv2_pkg::ADDR_W
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_ready,
  output logic              ap_idle,
  output logic              ap_done,
  input  logic [ADDR_W:0]   n_taps,
  input  logic [ADDR_W-1:0] act_base,
  input  logic [ADDR_W-1:0] wgt_base,
  output logic [ADDR_W-1:0] act_addr,
  output logic              act_ce,
  input  logic [A_W-1:0]    act_q,
  output logic [ADDR_W-1:0] wgt_addr,
  output logic              wgt_ce,
  input  logic [B_W-1:0]    wgt_q,
  output logic [A_W-1:0]    mul_a,
  output logic [B_W-1:0]    mul_b,
  input  logic [P_W-1:0]    mul_p,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_vld,
  input  logic              acc_ack
);
  import cnn_conv2_pkg::*;

  state_t            state, state_nx;
  logic [ADDR_W:0]   n_lat, k;
  logic [ADDR_W-1:0] abase, wbase;
  logic              dcnt;
  logic              accept, last, run;

  assign accept = (state == IDLE) && ap_start;
  assign run    = (state == RUN);
  assign last   = (k == n_lat - 1'b1);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
      n_lat <= '0;
      k     <= '0;
      abase <= '0;
      wbase <= '0;
      dcnt  <= 1'b0;
    end else begin
      state <= state_nx;
      dcnt  <= (state == DRAIN);
      if (accept) begin
        n_lat <= n_taps;
        abase <= act_base;
        wbase <= wgt_base;
        k     <= '0;
      end else if (run) begin
        k <= k + 1'b1;
      end
    end
  end

  // DRAIN covers the two pipeline stages behind the last read
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (ap_start) state_nx = (n_taps == '0) ? OUT : RUN;
      RUN:     if (last) state_nx = DRAIN;
      DRAIN:   if (dcnt) state_nx = OUT;
      OUT:     if (acc_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign ap_ready = accept;
  assign ap_idle  = (state == IDLE);
  assign acc_vld  = (state == OUT);
  assign ap_done  = acc_vld && acc_ack;
  assign act_ce   = run;
  assign wgt_ce   = run;
  assign act_addr = run ? abase + k[ADDR_W-1:0] : '0;
  assign wgt_addr = run ? wbase + k[ADDR_W-1:0] : '0;
  assign mul_a    = act_q;
  assign mul_b    = wgt_q;

  cnn_conv2_mac_acc #(.P_W(P_W), .ACC_W(ACC_W)) u_acc (
    .clk      (ap_clk),
    .rst_n    (ap_rst_n),
    .clr      (accept),
    .rd_issue (run),
    .mul_p    (mul_p),
    .acc      (acc_out)
  );
endmodule

// File: tb/tb_cnn_conv2_mac_sched.sv
// Scoreboard bench: driver pushes model results, negedge monitor pops and compares.
module tb_cnn_conv2_mac_sched;
  localparam int A_W = 14, B_W = 9, P_W = 23, ACC_W = 32, ADDR_W = 8;

  logic              ap_clk = 1'b0, ap_rst_n = 1'b0, ap_start = 1'b0, acc_ack = 1'b0;
  logic              ap_ready, ap_idle, ap_done, act_ce, wgt_ce, acc_vld;
  logic [ADDR_W:0]   n_taps = '0;
  logic [ADDR_W-1:0] act_base = '0, wgt_base = '0, act_addr, wgt_addr;
  logic [A_W-1:0]    act_q, mul_a;
  logic [B_W-1:0]    wgt_q, mul_b;
  logic [P_W-1:0]    mul_p;
  logic [ACC_W-1:0]  acc_out;

  cnn_conv2_mac_sched dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_idle(ap_idle), .ap_done(ap_done), .n_taps(n_taps), .act_base(act_base),
    .wgt_base(wgt_base), .act_addr(act_addr), .act_ce(act_ce), .act_q(act_q),
    .wgt_addr(wgt_addr), .wgt_ce(wgt_ce), .wgt_q(wgt_q), .mul_a(mul_a), .mul_b(mul_b),
    .mul_p(mul_p), .acc_out(acc_out), .acc_vld(acc_vld), .acc_ack(acc_ack)
  );

  always #5 ap_clk = ~ap_clk;

  // external buffers (1-cycle read) and multiplier
  logic signed [A_W-1:0] act_mem [256];
  logic signed [B_W-1:0] wgt_mem [256];
  always @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      act_q <= '0;
      wgt_q <= '0;
    end else begin
      if (act_ce) act_q <= act_mem[act_addr];
      if (wgt_ce) wgt_q <= wgt_mem[wgt_addr];
    end
  end
  assign mul_p = $signed(mul_a) * $signed(mul_b);

  int checks = 0, failures = 0;
  int exp_acc[$], exp_lat[$];
  int job_ab, job_wb, job_n, jobs = 0, accepts = 0;
  int cyc = 0, acc_cyc = 0, ce_cnt = 0;
  bit vld_seen = 1'b0;
  logic [ACC_W-1:0] held;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      if (ap_ready) begin
        acc_cyc = cyc; vld_seen = 1'b0; ce_cnt = 0; accepts++;
      end
      if (act_ce) begin
        chk("act_addr", act_addr, (job_ab + ce_cnt) % 256);
        chk("wgt_addr", wgt_addr, (job_wb + ce_cnt) % 256);
        chk("wgt_ce", wgt_ce, 1);
        ce_cnt++;
      end
      if (acc_vld) begin
        if (!vld_seen) begin
          vld_seen = 1'b1;
          held = acc_out;
          if (exp_lat.size() == 0) chk("latency_unexpected_vld", 1, 0);
          else chk("latency", cyc - acc_cyc, exp_lat.pop_front());
          chk("ce_count", ce_cnt, job_n);
        end else begin
          chk("acc_stable", acc_out, held);
        end
      end
      if (acc_vld || ap_done) chk("ap_done", ap_done, acc_vld && acc_ack);
      if (ap_done && acc_vld) begin
        if (exp_acc.size() == 0) chk("acc_unexpected", 1, 0);
        else chk("acc_out", longint'($signed(acc_out)), exp_acc.pop_front());
      end
    end
  end

  task automatic check_rst();
    chk("rst_ap_idle", ap_idle, 1);
    chk("rst_ap_ready", ap_ready, 0);
    chk("rst_ap_done", ap_done, 0);
    chk("rst_acc_vld", acc_vld, 0);
    chk("rst_act_ce", act_ce, 0);
    chk("rst_wgt_ce", wgt_ce, 0);
    chk("rst_act_addr", act_addr, 0);
    chk("rst_wgt_addr", wgt_addr, 0);
    chk("rst_acc_out", acc_out, 0);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 256; i++) begin
      act_mem[i] = A_W'($urandom);
      wgt_mem[i] = B_W'($urandom);
    end
  endtask

  // hold < 0: acc_ack high throughout; otherwise ack low for hold+1 cycles after acc_vld
  task automatic run_job(input int n, input int ab, input int wb, input int hold, input bit spur);
    int e = 0;
    bit got;
    for (int t = 0; t < n; t++)
      e += int'(act_mem[(ab + t) % 256]) * int'(wgt_mem[(wb + t) % 256]);
    exp_acc.push_back(e);
    exp_lat.push_back(n == 0 ? 1 : n + 3);
    job_ab = ab; job_wb = wb; job_n = n; jobs++;
    @(posedge ap_clk); #1;
    n_taps = 9'(n); act_base = 8'(ab); wgt_base = 8'(wb);
    acc_ack = (hold < 0); ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    if (spur) begin
      @(posedge ap_clk); #1 ap_start = 1'b1;
      @(posedge ap_clk); #1 ap_start = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) if (acc_vld) got = 1'b1; else @(negedge ap_clk);
    if (!got) chk("vld_timeout", 0, 1);
    if (hold >= 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge ap_clk); #1;
        ap_start = spur && (i == 0);
      end
      @(posedge ap_clk); #1;
      ap_start = 1'b0; acc_ack = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) if (ap_done) got = 1'b1; else @(negedge ap_clk);
    if (!got) chk("done_timeout", 0, 1);
    @(posedge ap_clk); #1;
    acc_ack = 1'b0;
    chk("accept_count", accepts, jobs);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=hang expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 check_rst();
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk) ap_rst_n = 1'b1;

    // 3-tap signed job: -2095596 at T6
    fill_rand();
    act_mem[10] = 14'(100); act_mem[11] = 14'(-200); act_mem[12] = 14'(8191);
    wgt_mem[20] = 9'(3);    wgt_mem[21] = 9'(-5);    wgt_mem[22] = 9'(-256);
    run_job(3, 10, 20, -1, 1'b0);

    // extreme operands over the full 256-tap range
    for (int i = 0; i < 256; i++) begin
      act_mem[i] = 14'(-8192);
      wgt_mem[i] = 9'(-256);
    end
    run_job(256, 0, 0, -1, 1'b0);

    fill_rand();
    run_job(4, 254, 253, 2, 1'b0);
    run_job(0, 5, 5, -1, 1'b0);
    run_job(0, 7, 9, 3, 1'b0);
    run_job(6, 30, 40, 5, 1'b1);

    for (int j = 0; j < 12; j++) begin
      fill_rand();
      run_job(int'($urandom_range(1, 40)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 4)) - 1, 1'b0);
    end

    // abort a job at tap 2, then a clean 1-tap job
    fill_rand();
    job_ab = 100; job_wb = 120; job_n = 8; jobs++;
    @(posedge ap_clk); #1;
    n_taps = 9'd8; act_base = 8'd100; wgt_base = 8'd120; ap_start = 1'b1;
    @(posedge ap_clk); #1 ap_start = 1'b0;
    @(posedge ap_clk);
    @(posedge ap_clk); #2;
    ap_rst_n = 1'b0;
    #1 check_rst();
    exp_acc.delete();
    exp_lat.delete();
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk) ap_rst_n = 1'b1;
    act_mem[50] = 14'(7);
    wgt_mem[60] = 9'(-3);
    run_job(1, 50, 60, -1, 1'b0);

    chk("scoreboard_empty", exp_acc.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
